udp_payload_packer: RTL and testbench

//   Upstream feeder for ethernet_udp_transmit. Packs a valid/ready byte stream

---
 rtl/udp_payload_packer_if.sv | 24 ++
 rtl/udp_payload_packer.sv | 156 +++++++++++++++
 tb/tb_udp_payload_packer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_payload_packer_if.sv
// Byte-stream in / payload-out bundle between a stream source, the packer and
// ethernet_udp_transmit. The packer takes the master view (it drives the payload,
// send and the stream backpressure); the environment takes the slave view.
interface udp_payload_packer_if #(
  parameter int unsigned DATA_BYTES = 16
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [8*DATA_BYTES-1:0] data;
  logic                    send;
  logic                    tx_ready;
  logic [15:0]             frame_count;

  modport master (
    input  in_data, in_valid, tx_ready,
    output in_ready, data, send, frame_count
  );

  modport slave (
    output in_data, in_valid, tx_ready,
    input  in_ready, data, send, frame_count
  );
endinterface

// File: rtl/udp_payload_packer.sv
// udp_payload_packer: packs a valid/ready byte stream into a DATA_BYTES-wide
// payload for ethernet_udp_transmit. A fill buffer collects bytes while the
// hold register (data) is on the wire; send is held until the transmitter
// drops ready, then the FSM waits for ready to return.
// Optional feature: define UDP_PAYLOAD_TIMEOUT_EN to flush a partial fill,
// padded with PAD_BYTE, after TIMEOUT_CYCLES idle cycles.
module udp_payload_packer #(
  parameter int unsigned DATA_BYTES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  udp_payload_packer_if.master bus
);

  localparam int unsigned PAY_W = 8 * DATA_BYTES;
  localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PAY_W-1:0]   fill_q,  fill_d;
  logic [PAY_W-1:0]   data_q,  data_d;
  logic               send_q,  send_d;
  logic [15:0]        frame_q, frame_d;
  logic               in_ready_c;
  logic               accept_c;

`ifdef UDP_PAYLOAD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   idle_q, idle_d;
  logic               timeout_c;
`else
  // Timeout knobs have no effect in this build.
  logic               unused_cfg;
  assign unused_cfg = ^{PAD_BYTE, 32'(TIMEOUT_CYCLES)};
`endif

  // Ready is derived from the registered fill count only.
  assign in_ready_c = (count_q != CNT_FULL);
  assign accept_c   = bus.in_valid && in_ready_c;

  assign bus.in_ready    = in_ready_c;
  assign bus.data        = data_q;
  assign bus.send        = send_q;
  assign bus.frame_count = frame_q;

  // Fill-side update, optional timeout flush, and transfer FSM next state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fill_d  = fill_q;
    data_d  = data_q;
    send_d  = send_q;
    frame_d = frame_q;
`ifdef UDP_PAYLOAD_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_c = (idle_q == TMO_W'(TIMEOUT_CYCLES));
`endif

    // Byte k of the datagram lands at fill[8*k +: 8].
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (accept_c && (count_q == CNT_W'(i))) begin
        fill_d[8*i +: 8] = bus.in_data;
      end
    end
    if (accept_c) begin
      count_d = count_q + CNT_W'(1);
    end

`ifdef UDP_PAYLOAD_TIMEOUT_EN
    // Idle counter runs only on a partial fill with no byte arriving.
    if (accept_c || (count_q == '0) || (count_q == CNT_FULL) || timeout_c) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + TMO_W'(1);
    end
    // A byte in the timeout cycle is already placed; pad everything after it.
    if (timeout_c) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        if (CNT_W'(i) >= count_d) begin
          fill_d[8*i +: 8] = PAD_BYTE;
        end
      end
      count_d = CNT_FULL;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        // Handoff: a full fill moves to the hold register once tx is ready.
        if ((count_q == CNT_FULL) && bus.tx_ready) begin
          data_d  = fill_q;
          count_d = '0;
          send_d  = 1'b1;
          frame_d = frame_q + 16'd1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Hold send until the transmitter shows it has taken the request.
        if (!bus.tx_ready) begin
          send_d  = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      send_q  <= send_d;
      frame_q <= frame_d;
    end
  end

`ifdef UDP_PAYLOAD_TIMEOUT_EN
  // Idle-cycle counter for the partial-fill flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

endmodule

// File: tb/tb_udp_payload_packer.sv
// Directed bench for udp_payload_packer with a scoreboard of expected payloads
// and a transmitter model that drops ready 2 cycles after send rises and
// raises it again 300 cycles later.
module tb_udp_payload_packer;

  localparam int unsigned DATA_BYTES = 16;
  localparam int unsigned PAY_W      = 8 * DATA_BYTES;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  udp_payload_packer_if #(.DATA_BYTES(DATA_BYTES)) bus ();

  udp_payload_packer #(
    .DATA_BYTES    (DATA_BYTES),
    .TIMEOUT_CYCLES(64),
    .PAD_BYTE      (8'hEE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [PAY_W-1:0] exp_q[$];
  logic [PAY_W-1:0] acc       = '0;
  int               acc_n     = 0;
  logic [PAY_W-1:0] last_pay  = '0;
  logic [PAY_W-1:0] exp1      = '0;
  logic [15:0]      exp_frames = 16'd0;
  logic             mon_prev  = 1'b0;

  // Transmitter ready model plus overrides.
  logic tx_block = 1'b0;
  logic model_en = 1'b1;
  logic m_rdy    = 1'b1;
  logic m_prev   = 1'b0;
  int   m_cnt    = 0;

  assign bus.tx_ready = tx_block ? 1'b0 : (model_en ? m_rdy : 1'b1);

  task automatic chk(input string tag, input logic [PAY_W-1:0] obs, input logic [PAY_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_cnt  = 0;
      m_rdy  = 1'b1;
      m_prev = 1'b0;
    end else begin
      if (bus.send && !m_prev) m_cnt = 1;
      else if (m_cnt != 0) m_cnt++;
      if (m_cnt == 2) m_rdy = 1'b0;
      if (m_cnt == 302) begin
        m_rdy = 1'b1;
        m_cnt = 0;
      end
      m_prev = bus.send;
    end
  end

  // Scoreboard: every send rising edge pops one expected payload.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mon_prev = 1'b0;
    end else begin
      if (bus.send && !mon_prev) begin
        chk("sb_nonempty", PAY_W'(exp_q.size() != 0), PAY_W'(1));
        if (exp_q.size() != 0) begin
          last_pay   = exp_q.pop_front();
          exp_frames = exp_frames + 16'd1;
          chk("sb_data", bus.data, last_pay);
          chk("sb_frame_count", PAY_W'(bus.frame_count), PAY_W'(exp_frames));
        end
      end
      mon_prev = bus.send;
    end
  end

  // Drive one byte from a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk("in_ready_wait_timeout", PAY_W'(0), PAY_W'(1));
    @(posedge clk);
    acc[8*acc_n +: 8] = b;
    acc_n++;
    if (acc_n == DATA_BYTES) begin
      exp_q.push_back(acc);
      acc   = '0;
      acc_n = 0;
    end
    @(negedge clk);
  endtask

  task automatic wait_quiet(input string tag);
    int w = 0;
    while (!(exp_q.size() == 0 && bus.send === 1'b0 && bus.tx_ready === 1'b1) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk(tag, PAY_W'(0), PAY_W'(1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_send", PAY_W'(bus.send), PAY_W'(0));
    chk("reset_data", bus.data, '0);
    chk("reset_frame_count", PAY_W'(bus.frame_count), PAY_W'(0));
    chk("reset_in_ready", PAY_W'(bus.in_ready), PAY_W'(1));
    reset = 1'b0;
    @(negedge clk);

    // 1: one datagram of 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      exp1[8*i +: 8] = 8'(i);
      send_byte(8'(i));
    end
    bus.in_valid = 1'b0;
    chk("t1_send_before_handoff", PAY_W'(bus.send), PAY_W'(0));
    chk("t1_in_ready_full", PAY_W'(bus.in_ready), PAY_W'(0));
    @(posedge clk);
    #1;
    chk("t1_send_rises", PAY_W'(bus.send), PAY_W'(1));
    chk("t1_data", bus.data, exp1);
    chk("t1_frame_count", PAY_W'(bus.frame_count), PAY_W'(1));
    w = 0;
    @(negedge clk);
    while (bus.send && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t1_send_falls", PAY_W'(bus.send), PAY_W'(0));
    chk("t1_tx_ready_low_at_fall", PAY_W'(bus.tx_ready), PAY_W'(0));
    wait_quiet("t1_quiet_timeout");

    // 2: 48 bytes streamed continuously
    for (int i = 0; i < 48; i++) begin
      send_byte(8'(i * 5 + 1));
      if (i == 31) begin
        bus.in_valid = 1'b0;
        chk("t2_in_ready_low_after_32", PAY_W'(bus.in_ready), PAY_W'(0));
        chk("t2_send_low_while_busy", PAY_W'(bus.send), PAY_W'(0));
        w = 0;
        while (!bus.in_ready && w < 1000) begin
          @(negedge clk);
          w++;
        end
        chk("t2_ready_returns_at_handoff", PAY_W'(bus.send), PAY_W'(1));
      end
    end
    bus.in_valid = 1'b0;
    wait_quiet("t2_quiet_timeout");
    chk("t2_frame_count", PAY_W'(bus.frame_count), PAY_W'(4));
    chk("t2_sb_drained", PAY_W'(exp_q.size()), PAY_W'(0));

    // 3: tx_ready held low at fill-full defers the handoff
    tx_block = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_send_deferred", PAY_W'(bus.send), PAY_W'(0));
    chk("t3_data_unchanged", bus.data, last_pay);
    chk("t3_in_ready_full", PAY_W'(bus.in_ready), PAY_W'(0));
    tx_block = 1'b0;
    @(posedge clk);
    #1;
    chk("t3_handoff_next_edge", PAY_W'(bus.send), PAY_W'(1));
    chk("t3_frame_count", PAY_W'(bus.frame_count), PAY_W'(5));
    wait_quiet("t3_quiet_timeout");

    // 4: reset during SEND with 7 bytes in the fill buffer
    model_en = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h50 + i));
    bus.in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h70 + i));
    bus.in_valid = 1'b0;
    chk("t4_in_send", PAY_W'(bus.send), PAY_W'(1));
    reset = 1'b1;
    #1;
    chk("t4_reset_send", PAY_W'(bus.send), PAY_W'(0));
    chk("t4_reset_data", bus.data, '0);
    chk("t4_reset_frame_count", PAY_W'(bus.frame_count), PAY_W'(0));
    chk("t4_reset_in_ready", PAY_W'(bus.in_ready), PAY_W'(1));
    acc        = '0;
    acc_n      = 0;
    exp_frames = 16'd0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    model_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h90 + i));
    bus.in_valid = 1'b0;
    wait_quiet("t4_quiet_timeout");
    chk("t4_frame_count", PAY_W'(bus.frame_count), PAY_W'(1));

`ifdef UDP_PAYLOAD_TIMEOUT_EN
    // 5: partial fill flushed with padding after the idle timeout
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
    bus.in_valid = 1'b0;
    for (int j = 5; j < 16; j++) acc[8*j +: 8] = 8'hEE;
    exp_q.push_back(acc);
    acc   = '0;
    acc_n = 0;
    chk("t5_in_ready_partial", PAY_W'(bus.in_ready), PAY_W'(1));
    w = 0;
    while (!bus.send && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("t5_send_after_timeout", PAY_W'(bus.send), PAY_W'(1));
    chk("t5_timeout_window", PAY_W'(w >= 60 && w <= 80), PAY_W'(1));
    wait_quiet("t5_quiet_timeout");
    chk("t5_frame_count", PAY_W'(bus.frame_count), PAY_W'(2));
`else
    // 6: partial fill waits indefinitely without the timeout feature
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
    bus.in_valid = 1'b0;
    repeat (10000) @(negedge clk);
    chk("t6_send_stays_low", PAY_W'(bus.send), PAY_W'(0));
    chk("t6_in_ready_high", PAY_W'(bus.in_ready), PAY_W'(1));
    chk("t6_frame_count", PAY_W'(bus.frame_count), PAY_W'(1));
`endif

    chk("final_sb_drained", PAY_W'(exp_q.size()), PAY_W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
